// File: rtl/tsn_q_pkg.sv
// Shared constants, state encoding and wire-time arithmetic for the TSN queue
// read side.
package tsn_q_pkg;

   localparam int DATASIZE = 41;
   localparam int LEN_W    = 11;
   localparam int BPC_LOG2 = 3;
   localparam int IFG_CYC  = 2;
   localparam int GATE_W   = 16;
   localparam int CNT_W    = 16;

   localparam int LEN_LSB = 0;
   localparam int LEN_MSB = LEN_W - 1;

   localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
   localparam logic [1:0] ST_CHECK_ENC = 2'd1;
   localparam logic [1:0] ST_SEND_ENC  = 2'd2;
   localparam logic [1:0] ST_BUSY_ENC  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = ST_IDLE_ENC,
      ST_CHECK = ST_CHECK_ENC,
      ST_SEND  = ST_SEND_ENC,
      ST_BUSY  = ST_BUSY_ENC
   } state_t;

   // Wire time plus gap; a zero-length descriptor still occupies one cycle.
   function automatic logic [GATE_W-1:0] calc_need(input logic [LEN_W-1:0] len);
      logic [GATE_W-1:0] tx_cyc;
      tx_cyc = (GATE_W'(len) + GATE_W'((1 << BPC_LOG2) - 1)) >> BPC_LOG2;
      if (len == '0) begin
         tx_cyc = GATE_W'(1);
      end
      return tx_cyc + GATE_W'(IFG_CYC);
   endfunction

endpackage

// File: rtl/tsn_wire_time.sv
// Combinational frame-length to required-gate-time calculator.
module tsn_wire_time
   import tsn_q_pkg::*;
(
   input  logic [LEN_W-1:0]  len,
   output logic [GATE_W-1:0] need
);

   assign need = calc_need(len);

endmodule

// File: rtl/tsn_queue_out_reader.sv
// Pops descriptors from a show-ahead queue, admits them through the gate with a
// guard band, offers them on valid/ready and then holds the port for wire time.
module tsn_queue_out_reader
   import tsn_q_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                q_empty,
   input  logic [DATASIZE-1:0] q_data,
   output logic                q_rd_en,
   input  logic                gate_open,
   input  logic [GATE_W-1:0]   gate_remaining,
   output logic                tx_vld,
   output logic [DATASIZE-1:0] tx_data,
   input  logic                tx_rdy,
   output logic                port_busy,
   output logic                guard_hold,
   output logic [CNT_W-1:0]    frame_cnt,
   output logic [CNT_W-1:0]    guard_cnt
);

   state_t              state;
   state_t              state_next;
   logic [DATASIZE-1:0] desc_q;
   logic [GATE_W-1:0]   busy_cnt;
   logic [GATE_W-1:0]   need;
   logic                load_desc;
   logic                launch;
   logic                xfer;
   logic                check_fail;

   tsn_wire_time u_wire_time (
      .len  (desc_q[LEN_MSB:LEN_LSB]),
      .need (need)
   );

   always_comb begin
      state_next = state;
      q_rd_en    = 1'b0;
      load_desc  = 1'b0;
      launch     = 1'b0;
      xfer       = 1'b0;
      check_fail = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!q_empty) begin
               q_rd_en    = 1'b1;
               load_desc  = 1'b1;
               state_next = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (gate_open && (gate_remaining >= need)) begin
               launch     = 1'b1;
               state_next = ST_SEND;
            end else begin
               check_fail = 1'b1;
            end
         end
         ST_SEND: begin
            // Committed frame: the gate is no longer consulted here.
            if (tx_rdy) begin
               xfer       = 1'b1;
               state_next = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (busy_cnt == '0) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      if (rst) begin
         q_rd_en = 1'b0;
      end
   end

   assign port_busy = (state == ST_SEND) || (state == ST_BUSY);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         desc_q     <= '0;
         tx_vld     <= 1'b0;
         tx_data    <= '0;
         busy_cnt   <= '0;
         guard_hold <= 1'b0;
         frame_cnt  <= '0;
         guard_cnt  <= '0;
      end else begin
         state      <= state_next;
         guard_hold <= check_fail;
         if (load_desc) begin
            desc_q <= q_data;
         end
         if (launch) begin
            tx_vld  <= 1'b1;
            tx_data <= desc_q;
         end
         if (xfer) begin
            tx_vld    <= 1'b0;
            frame_cnt <= frame_cnt + 1'b1;
            busy_cnt  <= need - 1'b1;
         end else if ((state == ST_BUSY) && (busy_cnt != '0)) begin
            busy_cnt <= busy_cnt - 1'b1;
         end
         if (check_fail && (guard_cnt != '1)) begin
            guard_cnt <= guard_cnt + 1'b1;
         end
      end
   end

endmodule

// File: doc/tsn_queue_out_reader.md
Name: tsn_queue_out_reader

Overview:
- Read-side consumer of the 41-bit descriptor queue that feeds the TSN egress port.
- Pops one descriptor at a time from a show-ahead queue, where data is valid whenever the queue is not empty.
- Applies the time-aware gate with a guard band: a frame starts only if it can finish, plus inter-frame gap, before the gate closes.
- Presents the descriptor on a valid/ready egress interface, then holds the port busy for the frame's wire time.

Parameters:
- DATASIZE, 41, descriptor width.
- LEN_W, 11, frame-length field width; field is desc[LEN_W-1:0], in bytes.
- BPC_LOG2, 3, log2 of bytes transmitted per clk cycle (8 B/cycle).
- IFG_CYC, 2, inter-frame gap in cycles.
- GATE_W, 16, width of the gate remaining-time input.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk, input, 1, single clock.
- rst, input, 1, synchronous reset, active-high.
- q_empty, input, 1, queue empty flag.
- q_data, input, DATASIZE, head descriptor; valid when q_empty=0.
- q_rd_en, output, 1, pop strobe; one cycle per descriptor.
- gate_open, input, 1, transmission gate for this queue.
- gate_remaining, input, GATE_W, cycles left until the gate closes; don't-care when gate_open=0.
- tx_vld, output, 1, descriptor offered to egress.
- tx_data, output, DATASIZE, offered descriptor.
- tx_rdy, input, 1, egress accepts; transfer happens when tx_vld and tx_rdy are both high.
- port_busy, output, 1, high while in SEND or BUSY.
- guard_hold, output, 1, high while a fetched frame is blocked by the gate or guard band.
- frame_cnt, output, CNT_W, count of accepted transfers; wraps.
- guard_cnt, output, CNT_W, cycles spent in guard_hold; saturates at all-ones.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE.
  - q_rd_en=0; it is forced 0 combinationally while rst=1.
  - tx_vld=0, tx_data=0, port_busy=0, guard_hold=0, frame_cnt=0, guard_cnt=0, desc_q=0, busy_cnt=0.
- Wire-time arithmetic:
  - tx_cyc = ceil(len / 2^BPC_LOG2).
  - len=0 is treated as tx_cyc=1.
  - need = tx_cyc + IFG_CYC, computed at GATE_W bits with no overflow. Maximum is 256+2=258.
- FSM states: IDLE, CHECK, SEND, BUSY.
- IDLE:
  - If q_empty=0: q_rd_en=1 in this cycle (combinational), desc_q<=q_data, go to CHECK.
  - Otherwise stay; q_rd_en=0.
- CHECK:
  - need is computed from the registered desc_q.
  - If gate_open=1 and gate_remaining >= need (equality passes): go to SEND, with tx_vld<=1 and tx_data<=desc_q.
  - Otherwise stay, guard_hold=1, guard_cnt increments (saturating). Re-evaluated every cycle.
- SEND:
  - tx_vld and tx_data are held stable until tx_rdy=1; no retraction.
  - gate_open and gate_remaining are ignored here, because the frame is committed.
  - On transfer: tx_vld<=0, frame_cnt+1, busy_cnt<=need-1, go to BUSY.
- BUSY:
  - busy_cnt decrements each cycle.
  - When busy_cnt=0, go to IDLE.
  - BUSY therefore lasts exactly need cycles.
- Latency:
  - A pop in cycle t (IDLE) gives CHECK at t+1.
  - tx_vld is first high at t+2 if the gate condition holds at t+1.
  - After the BUSY cycles, the next pop occurs on the first IDLE cycle.
- No pop occurs in CHECK, SEND or BUSY. At most one descriptor is in flight.
- q_rd_en is never asserted while q_empty=1.
- Reset mid-operation (CHECK, SEND or BUSY): the descriptor in flight is discarded and is not re-queued. All outputs take their reset values in the next cycle.
- guard_hold is a registered copy of the CHECK-fail condition and is cleared on leaving CHECK. It is 0 in IDLE, SEND and BUSY.

Decomposition:
- Package tsn_q_pkg:
  - DATASIZE, LEN_W, BPC_LOG2, IFG_CYC defaults.
  - Descriptor length-field offsets.
  - State encoding localparams.
  - Function calc_need(len) returning GATE_W bits.
- Sub-module tsn_wire_time: combinational len-to-need calculator. It is reused by the gate-control block's admission logic.
- The FSM, counters and egress register stay in tsn_queue_out_reader.

Test Plan:
- Reset with q_empty=0 and tx_rdy=1 → q_rd_en=0 during rst; tx_vld=0, frame_cnt=0, guard_cnt=0 the cycle after release; first pop occurs on the first IDLE cycle.
- One descriptor len=64, gate_open=1, gate_remaining=100, tx_rdy=1:
  - q_rd_en pulses 1 cycle at t.
  - tx_vld is high at t+2 for 1 cycle with tx_data equal to the descriptor.
  - port_busy is high for 1+10 cycles.
  - frame_cnt=1.
- Guard band, len=100 (tx_cyc=13, need=15):
  - gate_remaining=14 for 4 cycles → guard_hold=1, guard_cnt=4, tx_vld=0.
  - gate_remaining=15 → tx_vld next cycle.
  - gate_open=0 with remaining=200 → also held.
- Backpressure: tx_rdy=0 for 5 cycles while gate_open falls → tx_vld and tx_data stable for all 5 cycles; transfer completes when tx_rdy=1; frame_cnt+1.
- Back-to-back: three descriptors with len=8 and len=0,1 (each need=3), queue drains → q_rd_en pulses exactly 3 times, never in CHECK, SEND or BUSY and never when q_empty=1; frame_cnt=3.
- rst asserted in BUSY with busy_cnt=5 and q_empty=0 → next cycle IDLE, all outputs at reset values, no pop during rst, the discarded descriptor is not re-offered.
